sdram_ch0_arbiter: RTL and testbench
====================================

Name: sdram_ch0_arbiter

Overview:
- Shares the single SDRAM ch0 port (25-bit address, 8-bit data, rd/wr/busy handshake) between two requesters, e.g. the text-renderer fetch path (A) and the memory tester (B).
- Sequences each access through issue, wait-busy-rise, wait-busy-fall and complete.
- Schedules periodic refresh pulses, which take priority over new grants.
- Sits between the requesters in clk_sys and the sdram controller instance.

Parameters:
- ADDR_W, 25: ch0 address width.
- REFRESH_INTERVAL, 768: clk_sys cycles between refresh requests.
- REFRESH_PULSE, 2: cycles the refresh output is held high.
- START_TIMEOUT, 8: max WAIT_BUSY cycles before forced completion.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A level request; held until a_ack.
- a_wr  in  1  1=write, 0=read; stable while a_req is high.
- a_addr  in  ADDR_W  A address.
- a_din  in  8  A write data.
- a_ack  out  1  one-cycle completion pulse.
- a_dout  out  8  A read data; valid with a_ack, held until the next A read completes.
- b_req, b_wr, b_addr, b_din, b_ack, b_dout: same as A, for requester B.
- ch0_addr  out  ADDR_W  to sdram.
- ch0_wr  out  1  to sdram.
- ch0_rd  out  1  to sdram.
- ch0_din  out  8  to sdram.
- ch0_dout  in  8  from sdram.
- ch0_busy  in  1  from sdram.
- refresh  out  1  to sdram refresh input.
- grant  out  2  one-hot owner {B,A}; nonzero only in ISSUE through COMPLETE.
- timeout_err  out  1  one-cycle pulse when WAIT_BUSY times out.

Behaviour:
- Reset (async, reset_n low):
  - All outputs 0. State IDLE. Refresh counter 0. last_grant = B, so A wins the first tie.
  - Reset mid-transaction drops ch0_rd/ch0_wr immediately; no ack is issued.
- Refresh counter:
  - Increments every cycle in all states, saturating at REFRESH_INTERVAL.
  - refresh_due = (count >= REFRESH_INTERVAL).
  - Cleared to 0 on entry to REFRESH.
- IDLE, evaluated in priority order:
  - refresh_due -> REFRESH.
  - Else exactly one req high -> grant it.
  - Else both req high -> grant the requester not equal to last_grant (round-robin).
  - Else stay in IDLE.
  - On a grant, register ch0_addr/ch0_din from the winner and go to ISSUE.
- ISSUE (1 cycle):
  - Assert ch0_wr if the winner's wr=1, else ch0_rd. Never both.
  - Set grant. -> WAIT_BUSY with timeout counter 0.
- WAIT_BUSY:
  - Hold rd/wr.
  - ch0_busy=1 -> WAIT_DONE.
  - Timeout counter reaches START_TIMEOUT-1 with busy still 0 -> COMPLETE, pulse timeout_err.
- WAIT_DONE:
  - Hold rd/wr; ch0_busy=0 -> COMPLETE.
- COMPLETE (1 cycle):
  - Deassert ch0_rd/ch0_wr.
  - Pulse the owner's ack. For reads, capture ch0_dout into the owner's dout.
  - last_grant <= owner. -> IDLE. grant clears on exit.
- REFRESH:
  - refresh=1 for exactly REFRESH_PULSE cycles, with ch0_rd/ch0_wr low, then -> IDLE.
- Latency:
  - Request sampled in IDLE at cycle N -> ISSUE at N+1. With busy high at N+2 and low at N+3, ack is high at N+4.
  - Minimum 4 cycles from request sample to ack.
- Boundary conditions:
  - Refresh coming due mid-transaction is deferred to the next IDLE; it beats any pending req.
  - Requester dropping req mid-transaction: the transaction still completes and ack still pulses.
  - Requester re-asserting immediately after its ack while the other is waiting: the other is granted first.
  - ch0_addr/ch0_din remain stable from ISSUE through COMPLETE; request inputs are not resampled.
  - Write completions leave the owner's dout unchanged.
  - Counter saturation: no wrap; at most one refresh is owed.

Test Plan:
- Reset with reset_n=0, then release; hold a_req=0, b_req=0 -> outputs 0. After 768 cycles, refresh high exactly 2 cycles, then low; repeats every 768+ cycles.
- A read at addr 0x000012, sdram model busy at N+2..N+3 returning 0x12 -> ch0_rd high N+1..N+3, a_ack at N+4 (N+5 if busy lasts two cycles) with a_dout=0x12, grant=01 during the access.
- a_req and b_req asserted together continuously, both writing -> grants alternate A, B, A, B; ch0_din and ch0_addr match each owner; no ack is ever given to the non-owner.
- refresh_due and b_req rising in the same IDLE cycle -> REFRESH runs first (refresh=1 for 2 cycles), then B is issued. Refresh coming due during a B access -> no refresh until after b_ack.
- Busy never asserted -> after 8 WAIT_BUSY cycles, timeout_err and the ack pulse together; the FSM returns to IDLE.
- reset_n dropped during WAIT_DONE -> ch0_rd/ch0_wr/grant go 0 asynchronously and no ack; after release the next request is served normally.

Source files
------------

// File: rtl/sdram_ch0_arbiter.sv
// Two-requester arbiter for the SDRAM ch0 port: round-robin grants, a
// rd/wr handshake sequencer with start timeout, and periodic refresh pulses.
module sdram_ch0_arbiter #(
    parameter int ADDR_W           = 25,
    parameter int REFRESH_INTERVAL = 768,
    parameter int REFRESH_PULSE    = 2,
    parameter int START_TIMEOUT    = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_din,
    output logic              a_ack,
    output logic [7:0]        a_dout,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_din,
    output logic              b_ack,
    output logic [7:0]        b_dout,
    output logic [ADDR_W-1:0] ch0_addr,
    output logic              ch0_wr,
    output logic              ch0_rd,
    output logic [7:0]        ch0_din,
    input  logic [7:0]        ch0_dout,
    input  logic              ch0_busy,
    output logic              refresh,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int RC_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int RP_W = (REFRESH_PULSE > 1) ? $clog2(REFRESH_PULSE) : 1;
    localparam int TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(REFRESH_INTERVAL);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REFRESH_PULSE - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } req_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE,
        S_REFRESH
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [RP_W-1:0]   rp_q, rp_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              own_q, own_d;     // 0 = A, 1 = B
    logic              last_q, last_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              ref_q, ref_d;
    logic [1:0]        grant_q, grant_d;
    logic              tmo_q, tmo_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [7:0]        a_dout_q, a_dout_d;
    logic [7:0]        b_dout_q, b_dout_d;

    req_t req_a, req_b, win;
    logic refresh_due;
    logic pick_b;
    logic enter_done;

    assign req_a       = {a_wr, a_addr, a_din};
    assign req_b       = {b_wr, b_addr, b_din};
    assign refresh_due = (rcnt_q >= RC_MAX);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rcnt_q   <= '0;
            rp_q     <= '0;
            to_q     <= '0;
            own_q    <= 1'b0;
            last_q   <= 1'b1;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ref_q    <= 1'b0;
            grant_q  <= '0;
            tmo_q    <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            rp_q     <= rp_d;
            to_q     <= to_d;
            own_q    <= own_d;
            last_q   <= last_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ref_q    <= ref_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rcnt_d     = refresh_due ? rcnt_q : rcnt_q + RC_W'(1);
        rp_d       = rp_q;
        to_d       = to_q;
        own_d      = own_q;
        last_d     = last_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ref_d      = ref_q;
        grant_d    = grant_q;
        tmo_d      = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_dout_d   = a_dout_q;
        b_dout_d   = b_dout_q;
        enter_done = 1'b0;
        // B wins when it is alone, or on a tie when A was served last.
        pick_b     = b_req & (~a_req | ~last_q);
        win        = pick_b ? req_b : req_a;

        case (state_q)
            S_IDLE: begin
                if (refresh_due) begin
                    state_d = S_REFRESH;
                    rcnt_d  = '0;
                    rp_d    = '0;
                    ref_d   = 1'b1;
                end else if (a_req || b_req) begin
                    state_d = S_ISSUE;
                    own_d   = pick_b;
                    op_wr_d = win.wr;
                    addr_d  = win.addr;
                    din_d   = win.din;
                    wr_d    = win.wr;
                    rd_d    = ~win.wr;
                    grant_d = pick_b ? 2'b10 : 2'b01;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
                to_d    = '0;
            end
            S_WAIT_BUSY: begin
                if (ch0_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (to_q == TO_LAST) begin
                    enter_done = 1'b1;
                    tmo_d      = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!ch0_busy) enter_done = 1'b1;
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
                grant_d = '0;
                last_d  = own_q;
            end
            S_REFRESH: begin
                if (rp_q == RP_LAST) begin
                    state_d = S_IDLE;
                    ref_d   = 1'b0;
                end else begin
                    rp_d = rp_q + RP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Shared completion path for both normal finish and start timeout.
        if (enter_done) begin
            state_d = S_COMPLETE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            if (own_q) b_ack_d = 1'b1;
            else       a_ack_d = 1'b1;
            if (!op_wr_q) begin
                if (own_q) b_dout_d = ch0_dout;
                else       a_dout_d = ch0_dout;
            end
        end
    end

    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_dout      = a_dout_q;
    assign b_dout      = b_dout_q;
    assign ch0_addr    = addr_q;
    assign ch0_din     = din_q;
    assign ch0_rd      = rd_q;
    assign ch0_wr      = wr_q;
    assign refresh     = ref_q;
    assign grant       = grant_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sdram_ch0_arbiter.sv
// Directed bench for sdram_ch0_arbiter with a small busy-handshake sdram model.
module tb_sdram_ch0_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
    logic [24:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_din = '0, b_din = '0;
    logic        a_ack, b_ack, ch0_wr, ch0_rd, refresh, timeout_err;
    logic [7:0]  a_dout, b_dout, ch0_din;
    logic [24:0] ch0_addr;
    logic [1:0]  grant;
    logic [7:0]  ch0_dout = '0;
    logic        ch0_busy = 1'b0;

    int cyc = 0, base = 0, n_chk = 0, n_bad = 0;
    bit         m_on = 1'b1, m_act = 1'b0;
    int         m_len = 1;
    logic [7:0] m_rdata = '0;

    sdram_ch0_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din),
        .b_ack(b_ack), .b_dout(b_dout),
        .ch0_addr(ch0_addr), .ch0_wr(ch0_wr), .ch0_rd(ch0_rd),
        .ch0_din(ch0_din), .ch0_dout(ch0_dout), .ch0_busy(ch0_busy),
        .refresh(refresh), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Sdram model: busy rises the cycle after rd/wr appears, lasts m_len cycles.
    initial forever begin
        @(posedge clk_sys); #1;
        if (m_on && (ch0_rd || ch0_wr) && !m_act) begin
            m_act = 1'b1;
            @(posedge clk_sys); #1;
            ch0_busy = 1'b1;
            repeat (m_len) begin @(posedge clk_sys); #1; end
            ch0_busy = 1'b0;
            ch0_dout = m_rdata;
            while (ch0_rd || ch0_wr) begin @(posedge clk_sys); #1; end
            m_act = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        base = cyc;
    endtask

    task automatic to_edge(input int k);
        int g;
        g = 0;
        while ((cyc - base) < k && g < 5000) begin
            @(posedge clk_sys); #1;
            g++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        logic [1:0] eg;

        // reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_outs", {a_ack, b_ack, a_dout, b_dout, ch0_addr, ch0_wr, ch0_rd,
                         ch0_din, refresh, grant, timeout_err}, 64'h0);

        // refresh period with no requests
        do_reset();
        n = 0;
        do begin @(posedge clk_sys); #1; n++; end while (!refresh && n < 2000);
        chk("ref_first", n, 769);
        @(posedge clk_sys); #1; chk("ref_hi2", refresh, 1'b1);
        @(posedge clk_sys); #1; chk("ref_lo", refresh, 1'b0);
        n = 0;
        do begin @(posedge clk_sys); #1; n++; end while (!refresh && n < 2000);
        chk("ref_period", n, 767);

        // single reads: latency, data capture, req drop mid-transaction, write keeps dout
        do_reset();
        m_len = 1; m_rdata = 8'h12;
        a_wr = 1'b0; a_addr = 25'h12; a_req = 1'b1;
        to_edge(1);
        chk("rd_issue", {ch0_rd, ch0_wr, grant, a_ack}, {1'b1, 1'b0, 2'b01, 1'b0});
        chk("rd_addr", ch0_addr, 25'h12);
        to_edge(3);
        chk("rd_hold", {ch0_rd, a_ack}, 2'b10);
        to_edge(4);
        chk("rd_ack", {a_ack, a_dout, ch0_rd, grant}, {1'b1, 8'h12, 1'b0, 2'b01});
        a_req = 1'b0;
        to_edge(5);
        chk("rd_after", {a_ack, grant}, 3'b000);
        m_len = 2; m_rdata = 8'h34; a_addr = 25'h34; a_req = 1'b1;
        to_edge(7);
        a_req = 1'b0;
        to_edge(9);
        chk("rd2_noack", a_ack, 1'b0);
        to_edge(10);
        chk("rd2_ack", {a_ack, a_dout}, {1'b1, 8'h34});
        m_len = 1; m_rdata = 8'hEE;
        a_wr = 1'b1; a_din = 8'h99; a_addr = 25'h200; a_req = 1'b1;
        n = 0;
        do begin @(posedge clk_sys); #1; n++; end while (!a_ack && n < 50);
        chk("wr_ack", a_ack, 1'b1);
        chk("wr_dout_kept", a_dout, 8'h34);
        a_req = 1'b0;

        // both requesters writing continuously: strict alternation
        do_reset();
        a_wr = 1'b1; b_wr = 1'b1;
        a_addr = 25'h100; a_din = 8'hA1;
        b_addr = 25'h1ABCDEF; b_din = 8'hB2;
        m_rdata = 8'h5A; m_len = 1;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            do begin @(posedge clk_sys); #1; n++; end while (grant == 2'b00 && n < 20);
            chk("alt_grant", grant, eg);
            chk("alt_addr", ch0_addr, eg[1] ? 25'h1ABCDEF : 25'h100);
            chk("alt_din", ch0_din, eg[1] ? 8'hB2 : 8'hA1);
            chk("alt_wr_rd", {ch0_wr, ch0_rd}, 2'b10);
            n = 0;
            do begin @(posedge clk_sys); #1; n++; end while (!(a_ack || b_ack) && n < 20);
            chk("alt_ack", {b_ack, a_ack}, eg);
            chk("alt_addr_hold", ch0_addr, eg[1] ? 25'h1ABCDEF : 25'h100);
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("alt_dout_kept", {a_dout, b_dout}, 16'h0000);

        // refresh vs request in the same IDLE cycle, then refresh deferred by an access
        do_reset();
        m_len = 1; m_rdata = 8'hC3;
        to_edge(768);
        b_wr = 1'b0; b_addr = 25'h0ABCDE; b_req = 1'b1;
        to_edge(769);
        chk("rf_first", {refresh, grant}, {1'b1, 2'b00});
        to_edge(770);
        chk("rf_hold", refresh, 1'b1);
        to_edge(771);
        chk("rf_end", {refresh, grant}, 3'b000);
        to_edge(772);
        chk("rf_b_issue", {grant, ch0_rd}, {2'b10, 1'b1});
        to_edge(775);
        chk("rf_b_ack", {b_ack, b_dout}, {1'b1, 8'hC3});
        b_req = 1'b0;
        m_len = 6; m_rdata = 8'h3C;
        to_edge(1533);
        b_req = 1'b1;
        seen = 1'b0;
        for (int k = 1534; k <= 1542; k++) begin
            to_edge(k);
            if (refresh) seen = 1'b1;
        end
        chk("defer_ack", {b_ack, b_dout}, {1'b1, 8'h3C});
        chk("defer_no_ref", seen, 1'b0);
        b_req = 1'b0;
        to_edge(1543);
        chk("defer_idle", refresh, 1'b0);
        to_edge(1544);
        chk("defer_ref", {refresh, grant}, {1'b1, 2'b00});

        // busy never arrives: timeout
        do_reset();
        m_on = 1'b0;
        a_wr = 1'b0; a_addr = 25'h7; a_req = 1'b1;
        to_edge(9);
        chk("to_wait", {a_ack, timeout_err, ch0_rd}, 3'b001);
        to_edge(10);
        chk("to_fire", {a_ack, timeout_err, ch0_rd}, 3'b110);
        a_req = 1'b0;
        to_edge(11);
        chk("to_idle", {a_ack, timeout_err, grant}, 4'b0000);
        m_on = 1'b1;

        // reset during WAIT_DONE, then normal service
        do_reset();
        m_len = 4; m_rdata = 8'h55;
        a_wr = 1'b0; a_addr = 25'h55; a_req = 1'b1;
        to_edge(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst", {ch0_rd, ch0_wr, grant, a_ack}, 5'b00000);
        a_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin @(posedge clk_sys); #1; if (a_ack) seen = 1'b1; end
        chk("mid_rst_noack", seen, 1'b0);
        reset_n = 1'b1;
        base = cyc;
        n = 0;
        while (m_act && n < 50) begin @(posedge clk_sys); #1; n++; end
        m_len = 1; m_rdata = 8'h77; a_addr = 25'h66; a_req = 1'b1;
        n = 0;
        do begin @(posedge clk_sys); #1; n++; end while (!a_ack && n < 50);
        chk("post_rst_lat", n, 4);
        chk("post_rst_data", {a_ack, a_dout}, {1'b1, 8'h77});
        a_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
